// File: rtl/mag_cal_apply.sv
`default_nettype none
// mag_cal_apply: hard-iron offset, per-axis gain, soft-iron matrix and squared magnitude,
// all sequenced over one shared signed W x W multiplier. Rev 1.0
module mag_cal_apply #(
  parameter int W    = 24,
  parameter int FRAC = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] raw_x,
  input  logic signed [W-1:0] raw_y,
  input  logic signed [W-1:0] raw_z,
  input  logic signed [W-1:0] offset_x,
  input  logic signed [W-1:0] offset_y,
  input  logic signed [W-1:0] offset_z,
  input  logic signed [W-1:0] gain_x,
  input  logic signed [W-1:0] gain_y,
  input  logic signed [W-1:0] gain_z,
  input  logic signed [W-1:0] m00, m01, m02,
  input  logic signed [W-1:0] m10, m11, m12,
  input  logic signed [W-1:0] m20, m21, m22,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y,
  output logic signed [W-1:0] out_z,
  output logic [31:0]         out_mag2,
  output logic                out_valid,
  output logic                busy
);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 2;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_OFFS = 3'd1, ST_GAIN = 3'd2,
    ST_MAT  = 3'd3, ST_MAG  = 3'd4, ST_DONE = 3'd5
  } state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  logic signed [W-1:0] raw_in [3];
  logic signed [W-1:0] off_in [3];
  logic signed [W-1:0] gain_in [3];
  logic signed [W-1:0] m_in [9];

  assign raw_in  = '{raw_x, raw_y, raw_z};
  assign off_in  = '{offset_x, offset_y, offset_z};
  assign gain_in = '{gain_x, gain_y, gain_z};
  assign m_in    = '{m00, m01, m02, m10, m11, m12, m20, m21, m22};

  state_t              state_q, state_d;
  logic [1:0]          i_q, i_d, j_q, j_d;
  logic signed [W-1:0] raw_q [3], raw_d [3];
  logic signed [W-1:0] off_q [3], off_d [3];
  logic signed [W-1:0] gain_q [3], gain_d [3];
  logic signed [W-1:0] m_q [9], m_d [9];
  logic signed [W-1:0] dv_q [3], dv_d [3];
  logic signed [W-1:0] g_q [3], g_d [3];
  logic signed [W-1:0] c_q [3], c_d [3];
  logic signed [AW-1:0] acc_q, acc_d;
  logic [AW-1:0]       s_q, s_d;
  logic signed [W-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic [31:0]         out_mag2_q, out_mag2_d;

  logic signed [W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext, prod_shr, acc_sum, acc_shr;
  logic [AW-1:0]        s_sum, s_shr;
  logic                 m_all_zero;
  logic [3:0]           m_idx;

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign prod_shr = prod_ext >>> FRAC;
  assign acc_sum  = ((j_q == 2'd0) ? '0 : acc_q) + prod_ext;
  assign acc_shr  = acc_sum >>> FRAC;
  // Squares are never negative, so the product is zero-extended into the unsigned sum.
  assign s_sum    = ((j_q == 2'd0) ? '0 : s_q) + {{(AW-PW){1'b0}}, prod};
  assign s_shr    = s_sum >> FRAC;
  assign m_idx    = 4'(i_q) * 4'd3 + 4'(j_q);

  always_comb begin
    m_all_zero = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (m_q[k] != '0) m_all_zero = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    raw_d      = raw_q;
    off_d      = off_q;
    gain_d     = gain_q;
    m_d        = m_q;
    dv_d       = dv_q;
    g_d        = g_q;
    c_d        = c_q;
    acc_d      = acc_q;
    s_d        = s_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_z_d    = out_z_q;
    out_mag2_d = out_mag2_q;
    mul_a      = '0;
    mul_b      = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          raw_d   = raw_in;
          off_d   = off_in;
          gain_d  = gain_in;
          m_d     = m_in;
          state_d = ST_OFFS;
        end
      end
      ST_OFFS: begin
        for (int k = 0; k < 3; k++) begin
          dv_d[k] = sat_w({{(AW-W){raw_q[k][W-1]}}, raw_q[k]} - {{(AW-W){off_q[k][W-1]}}, off_q[k]});
        end
        j_d     = 2'd0;
        state_d = ST_GAIN;
      end
      ST_GAIN: begin
        mul_a     = dv_q[j_q];
        mul_b     = gain_q[j_q];
        g_d[j_q]  = sat_w(prod_shr);
        if (j_q == 2'd2) begin
          j_d = 2'd0;
          i_d = 2'd0;
          if (m_all_zero) begin
            // Identity bypass: the z gain result is only available combinationally here.
            c_d[0]  = g_q[0];
            c_d[1]  = g_q[1];
            c_d[2]  = sat_w(prod_shr);
            state_d = ST_MAG;
          end else begin
            state_d = ST_MAT;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      ST_MAT: begin
        mul_a = m_q[m_idx];
        mul_b = g_q[j_q];
        acc_d = acc_sum;
        if (j_q == 2'd2) begin
          c_d[i_q] = sat_w(acc_shr);
          j_d      = 2'd0;
          if (i_q == 2'd2) begin
            i_d     = 2'd0;
            state_d = ST_MAG;
          end else begin
            i_d = i_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      ST_MAG: begin
        mul_a = c_q[j_q];
        mul_b = c_q[j_q];
        s_d   = s_sum;
        if (j_q == 2'd2) begin
          // Results land on the edge entering DONE so they coincide with out_valid.
          out_x_d    = c_q[0];
          out_y_d    = c_q[1];
          out_z_d    = c_q[2];
          out_mag2_d = (|s_shr[AW-1:32]) ? 32'hFFFF_FFFF : s_shr[31:0];
          j_d        = 2'd0;
          state_d    = ST_DONE;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      s_q        <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_z_q    <= '0;
      out_mag2_q <= '0;
      for (int k = 0; k < 3; k++) begin
        raw_q[k]  <= '0;
        off_q[k]  <= '0;
        gain_q[k] <= '0;
        dv_q[k]   <= '0;
        g_q[k]    <= '0;
        c_q[k]    <= '0;
      end
      for (int k = 0; k < 9; k++) m_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      s_q        <= s_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_z_q    <= out_z_d;
      out_mag2_q <= out_mag2_d;
      raw_q      <= raw_d;
      off_q      <= off_d;
      gain_q     <= gain_d;
      dv_q       <= dv_d;
      g_q        <= g_d;
      c_q        <= c_d;
      m_q        <= m_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_mag2  = out_mag2_q;

endmodule
`default_nettype wire
